// File: rtl/resp_capture_checker.sv
// Captures one response bit per stimulus vector, then compares the table against GOLDEN.
// Optional MISR signature over in-order responses is enabled with RESP_SIG_MISR_EN.
module resp_capture_checker #(
    parameter int N_BITS = 4,
    parameter logic [(1 << N_BITS)-1:0] GOLDEN = '0
) (
    input  logic                       CK,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N_BITS-1:0]          N,
    input  logic                       output_single,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       seq_err,
    output logic [N_BITS:0]            mismatch_cnt,
    output logic [N_BITS-1:0]          first_fail,
    output logic [(1 << N_BITS)-1:0]   captured,
    output logic [15:0]                signature
);

    // state   | meaning
    // IDLE    | waiting for start, results held
    // CAPTURE | accepting in-order responses
    // COMPARE | scanning one table entry per cycle
    // DONE    | latch pass, pulse done on the way back to IDLE
    typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, DONE} state_t;

    localparam logic [N_BITS-1:0] LAST_IDX = {N_BITS{1'b1}};
    localparam logic [N_BITS:0]   MAX_CNT  = {1'b1, {N_BITS{1'b0}}};

    state_t            state, state_next;
    logic [N_BITS-1:0] exp_idx;
    logic [N_BITS-1:0] scan_idx;
    logic              xfer;
    logic              in_order;
    logic              run_start;

    assign in_ready  = (state == CAPTURE);
    assign busy      = (state != IDLE);
    assign xfer      = in_valid && in_ready;
    assign in_order  = (N == exp_idx);
    assign run_start = (state == IDLE) && start;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CAPTURE;
            CAPTURE: if (xfer && in_order && exp_idx == LAST_IDX) state_next = COMPARE;
            COMPARE: if (scan_idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!reset) begin
            state        <= IDLE;
            exp_idx      <= '0;
            scan_idx     <= '0;
            captured     <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            seq_err      <= 1'b0;
            pass         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_idx      <= '0;
                        scan_idx     <= '0;
                        captured     <= '0;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        seq_err      <= 1'b0;
                        pass         <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (xfer) begin
                        if (in_order) begin
                            captured[N] <= output_single;
                            // exp_idx parks on the last index instead of wrapping
                            if (exp_idx != LAST_IDX) exp_idx <= exp_idx + 1'b1;
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                end
                COMPARE: begin
                    if (captured[scan_idx] != GOLDEN[scan_idx]) begin
                        if (mismatch_cnt == '0) first_fail <= scan_idx;
                        if (mismatch_cnt != MAX_CNT) mismatch_cnt <= mismatch_cnt + 1'b1;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                DONE: begin
                    // final scan result is only visible here, one cycle after the last compare
                    pass <= (mismatch_cnt == '0) && !seq_err;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef RESP_SIG_MISR_EN
    logic [15:0] misr;
    logic        misr_fb;

    assign misr_fb   = misr[15] ^ output_single;
    assign signature = misr;

    // Galois form of x^16+x^12+x^5+1
    always_ff @(posedge CK) begin
        if (!reset) begin
            misr <= '0;
        end else if (run_start) begin
            misr <= 16'hFFFF;
        end else if (xfer && in_order) begin
            misr <= {misr[14:0], 1'b0} ^ (misr_fb ? 16'h1021 : 16'h0000);
        end
    end
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_resp_capture_checker.sv
// Directed bench for resp_capture_checker (N_BITS=4, GOLDEN all zero).
module tb_resp_capture_checker;

    logic        CK = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  N;
    logic        output_single;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic        seq_err;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic [15:0] captured;
    logic [15:0] signature;

    int total = 0;
    int bad   = 0;
    int lat;
    int saw_done;

    resp_capture_checker #(.N_BITS(4), .GOLDEN(16'h0000)) dut (
        .CK(CK), .reset(reset), .start(start), .N(N),
        .output_single(output_single), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .seq_err(seq_err), .mismatch_cnt(mismatch_cnt),
        .first_fail(first_fail), .captured(captured), .signature(signature)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int idx, input logic bit_val);
        N             = idx[3:0];
        output_single = bit_val;
        in_valid      = 1'b1;
        tick();
        in_valid      = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_table(input logic [15:0] resp, output int cycles);
        pulse_start();
        for (int i = 0; i < 16; i++) send(i, resp[i]);
        wait_done(cycles);
    endtask

`ifdef RESP_SIG_MISR_EN
    function automatic logic [15:0] misr_ref(input logic [15:0] resp);
        logic [15:0] s;
        logic        fb;
        s = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            fb = s[15] ^ resp[i];
            s  = {s[14:0], 1'b0};
            if (fb) s = s ^ 16'h1021;
        end
        return s;
    endfunction
`endif

    initial begin
        reset = 1'b0; start = 1'b0; N = '0; output_single = 1'b0; in_valid = 1'b0;
        tick(); tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ready", {31'b0, in_ready}, 0);
        check("rst_outputs", {done, pass, seq_err, mismatch_cnt, first_fail, captured}, 0);
        check("rst_sig", {16'b0, signature}, 0);
        reset = 1'b1;
        tick();

        // Scenario 1: all-zero responses
        pulse_start();
        check("s1_busy", {31'b0, busy}, 1);
        check("s1_ready", {31'b0, in_ready}, 1);
        for (int i = 0; i < 16; i++) send(i, 1'b0);
        check("s1_ready_off", {31'b0, in_ready}, 0);
        wait_done(lat);
        check("s1_latency", lat, 17);
        check("s1_pass", {31'b0, pass}, 1);
        check("s1_cnt", {27'b0, mismatch_cnt}, 0);
        check("s1_ff", {28'b0, first_fail}, 0);
        check("s1_captured", {16'b0, captured}, 0);
        check("s1_busy_end", {31'b0, busy}, 0);
`ifdef RESP_SIG_MISR_EN
        check("s1_sig", {16'b0, signature}, {16'b0, misr_ref(16'h0000)});
`else
        check("s1_sig", {16'b0, signature}, 0);
`endif
        tick();
        check("s1_done_pulse", {31'b0, done}, 0);
        check("s1_hold_pass", {31'b0, pass}, 1);

        // Scenario 2: mismatches at 5 and 9
        run_table(16'h0220, lat);
        check("s2_latency", lat, 17);
        check("s2_pass", {31'b0, pass}, 0);
        check("s2_cnt", {27'b0, mismatch_cnt}, 2);
        check("s2_ff", {28'b0, first_fail}, 5);
        check("s2_captured", {16'b0, captured}, 32'h0220);
`ifdef RESP_SIG_MISR_EN
        check("s2_sig", {16'b0, signature}, {16'b0, misr_ref(16'h0220)});
`endif

        // Scenario 3: vector 3 sent as 4 with data 1, which must be dropped
        pulse_start();
        check("s3_cleared", {pass, seq_err, mismatch_cnt, first_fail, captured}, 0);
        for (int i = 0; i < 3; i++) send(i, 1'b0);
        send(4, 1'b1);
        check("s3_seq_err", {31'b0, seq_err}, 1);
        check("s3_dropped", {16'b0, captured}, 0);
        for (int i = 3; i < 16; i++) send(i, 1'b0);
        wait_done(lat);
        check("s3_latency", lat, 17);
        check("s3_pass", {31'b0, pass}, 0);
        check("s3_cnt", {27'b0, mismatch_cnt}, 0);
        check("s3_seq_sticky", {31'b0, seq_err}, 1);

        // Scenario 4: reset after 8 transfers aborts the run
        pulse_start();
        for (int i = 0; i < 8; i++) send(i, 1'b1);
        reset = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        reset = 1'b1;
        check("s4_idle", {30'b0, busy, in_ready}, 0);
        check("s4_outputs", {done, pass, seq_err, mismatch_cnt, first_fail, captured}, 0);
        check("s4_sig", {16'b0, signature}, 0);
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        check("s4_no_done", saw_done, 0);
        run_table(16'h8000, lat);
        check("s4_latency", lat, 17);
        check("s4_cnt", {27'b0, mismatch_cnt}, 1);
        check("s4_ff", {28'b0, first_fail}, 15);
        check("s4_pass", {31'b0, pass}, 0);

        // every entry wrong: count reaches DEPTH
        run_table(16'hFFFF, lat);
        check("sat_cnt", {27'b0, mismatch_cnt}, 16);
        check("sat_ff", {28'b0, first_fail}, 0);

        // Scenario 5: random valid gaps and stray start pulses
        pulse_start();
        begin
            int idx;
            int budget;
            logic [15:0] resp;
            resp = 16'h3C5A;
            idx = 0;
            budget = 0;
            while (idx < 16 && budget < 300) begin
                in_valid      = ($urandom_range(0, 1) == 1);
                start         = ($urandom_range(0, 1) == 1);
                N             = idx[3:0];
                output_single = resp[idx];
                tick();
                if (in_valid) idx++;
                budget++;
            end
            in_valid = 1'b0;
            start    = 1'b0;
            check("s5_all_sent", idx, 16);
        end
        wait_done(lat);
        check("s5_latency", lat, 17);
        check("s5_captured", {16'b0, captured}, 32'h3C5A);
        check("s5_cnt", {27'b0, mismatch_cnt}, 8);
        check("s5_ff", {28'b0, first_fail}, 1);
        check("s5_seq_err", {31'b0, seq_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
